// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter.
package mfp_ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_addr_hold.sv
// One-entry address/control hold register for a single master plus the
// mux that picks the held entry over the live master inputs.
import mfp_ahb_lite_pkg::*;

module mfp_ahb_lite_addr_hold #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  release_pend,
    input  logic [ADDR_WIDTH-1:0] live_haddr,
    input  logic [2:0]            live_hburst,
    input  logic [2:0]            live_hsize,
    input  logic [3:0]            live_hprot,
    input  logic [1:0]            live_htrans,
    input  logic                  live_hwrite,
    input  logic                  live_hmastlock,
    output logic [ADDR_WIDTH-1:0] src_haddr,
    output logic [2:0]            src_hburst,
    output logic [2:0]            src_hsize,
    output logic [3:0]            src_hprot,
    output logic [1:0]            src_htrans,
    output logic                  src_hwrite,
    output logic                  src_hmastlock,
    output logic                  pending
);

    logic                  pend_q,     pend_d;
    logic [ADDR_WIDTH-1:0] haddr_q,    haddr_d;
    logic [2:0]            hburst_q,   hburst_d;
    logic [2:0]            hsize_q,    hsize_d;
    logic [3:0]            hprot_q,    hprot_d;
    logic [1:0]            htrans_q,   htrans_d;
    logic                  hwrite_q,   hwrite_d;
    logic                  hmastlock_q, hmastlock_d;

    // Next-state: load on capture, drop once the held transfer is forwarded.
    always_comb begin
        pend_d      = pend_q;
        haddr_d     = haddr_q;
        hburst_d    = hburst_q;
        hsize_d     = hsize_q;
        hprot_d     = hprot_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hmastlock_d = hmastlock_q;
        if (capture) begin
            pend_d      = 1'b1;
            haddr_d     = live_haddr;
            hburst_d    = live_hburst;
            hsize_d     = live_hsize;
            hprot_d     = live_hprot;
            htrans_d    = live_htrans;
            hwrite_d    = live_hwrite;
            hmastlock_d = live_hmastlock;
        end else if (release_pend) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Hold register; a reset discards any held transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            haddr_q     <= '0;
            hburst_q    <= 3'b000;
            hsize_q     <= 3'b000;
            hprot_q     <= 4'b0000;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hmastlock_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            haddr_q     <= haddr_d;
            hburst_q    <= hburst_d;
            hsize_q     <= hsize_d;
            hprot_q     <= hprot_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    // Source mux: a held transfer always takes precedence over live inputs.
    always_comb begin
        pending = pend_q;
        if (pend_q) begin
            src_haddr     = haddr_q;
            src_hburst    = hburst_q;
            src_hsize     = hsize_q;
            src_hprot     = hprot_q;
            src_htrans    = htrans_q;
            src_hwrite    = hwrite_q;
            src_hmastlock = hmastlock_q;
        end else begin
            src_haddr     = live_haddr;
            src_hburst    = live_hburst;
            src_hsize     = live_hsize;
            src_hprot     = live_hprot;
            src_htrans    = live_htrans;
            src_hwrite    = live_hwrite;
            src_hmastlock = live_hmastlock;
        end
    end

endmodule

// File: rtl/mfp_ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter: grants one address phase per cycle onto the
// shared bus, parks the losing master in its hold register, and routes the
// data-phase response back to the master that owns it.
import mfp_ahb_lite_pkg::*;

module mfp_ahb_lite_arbiter #(
    parameter int ROUND_ROBIN = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [2:0]            M0_HBURST,
    input  logic [2:0]            M0_HSIZE,
    input  logic [3:0]            M0_HPROT,
    input  logic [1:0]            M0_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic                  M0_HMASTLOCK,
    input  logic [31:0]           M0_HWDATA,
    output logic [31:0]           M0_HRDATA,
    output logic                  M0_HREADY,
    output logic                  M0_HRESP,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [2:0]            M1_HBURST,
    input  logic [2:0]            M1_HSIZE,
    input  logic [3:0]            M1_HPROT,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M1_HWRITE,
    input  logic                  M1_HMASTLOCK,
    input  logic [31:0]           M1_HWDATA,
    output logic [31:0]           M1_HRDATA,
    output logic                  M1_HREADY,
    output logic                  M1_HRESP,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic                  HMASTLOCK,
    output logic [3:0]            HPROT,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  HMASTER
);

    logic [ADDR_WIDTH-1:0] src_haddr_s     [2];
    logic [2:0]            src_hburst_s    [2];
    logic [2:0]            src_hsize_s     [2];
    logic [3:0]            src_hprot_s     [2];
    logic [1:0]            src_htrans_s    [2];
    logic                  src_hwrite_s    [2];
    logic                  src_hmastlock_s [2];
    logic                  pending_s       [2];
    logic                  capture_s       [2];
    logic                  release_s       [2];
    logic                  mx_hready_s     [2];
    logic                  live_active_s   [2];
    logic                  src_active_s    [2];
    logic                  grant_s, grant_active_s, fwd_s;

    logic dp_valid_q,   dp_valid_d;
    logic dp_owner_q,   dp_owner_d;
    logic last_grant_q, last_grant_d;
    logic lock_q,       lock_d;

    mfp_ahb_lite_addr_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold0 (
        .clk(HCLK), .rst(HRESET), .capture(capture_s[0]), .release_pend(release_s[0]),
        .live_haddr(M0_HADDR), .live_hburst(M0_HBURST), .live_hsize(M0_HSIZE),
        .live_hprot(M0_HPROT), .live_htrans(M0_HTRANS), .live_hwrite(M0_HWRITE),
        .live_hmastlock(M0_HMASTLOCK),
        .src_haddr(src_haddr_s[0]), .src_hburst(src_hburst_s[0]), .src_hsize(src_hsize_s[0]),
        .src_hprot(src_hprot_s[0]), .src_htrans(src_htrans_s[0]), .src_hwrite(src_hwrite_s[0]),
        .src_hmastlock(src_hmastlock_s[0]), .pending(pending_s[0])
    );

    mfp_ahb_lite_addr_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold1 (
        .clk(HCLK), .rst(HRESET), .capture(capture_s[1]), .release_pend(release_s[1]),
        .live_haddr(M1_HADDR), .live_hburst(M1_HBURST), .live_hsize(M1_HSIZE),
        .live_hprot(M1_HPROT), .live_htrans(M1_HTRANS), .live_hwrite(M1_HWRITE),
        .live_hmastlock(M1_HMASTLOCK),
        .src_haddr(src_haddr_s[1]), .src_hburst(src_hburst_s[1]), .src_hsize(src_hsize_s[1]),
        .src_hprot(src_hprot_s[1]), .src_htrans(src_htrans_s[1]), .src_hwrite(src_hwrite_s[1]),
        .src_hmastlock(src_hmastlock_s[1]), .pending(pending_s[1])
    );

    // Grant: lock/burst continuation first, then priority or alternation.
    always_comb begin
        live_active_s[0] = trans_active(M0_HTRANS);
        live_active_s[1] = trans_active(M1_HTRANS);
        src_active_s[0]  = trans_active(src_htrans_s[0]);
        src_active_s[1]  = trans_active(src_htrans_s[1]);
        grant_s          = last_grant_q;
        if (lock_q) begin
            grant_s = last_grant_q;
        end else if (src_htrans_s[0] == HTRANS_SEQ) begin
            grant_s = 1'b0;
        end else if (src_htrans_s[1] == HTRANS_SEQ) begin
            grant_s = 1'b1;
        end else if (src_active_s[0] && src_active_s[1]) begin
            grant_s = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
        end else if (src_active_s[0]) begin
            grant_s = 1'b0;
        end else if (src_active_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = last_grant_q;
        end
        grant_active_s = src_active_s[grant_s];
        fwd_s          = grant_active_s && HREADY;
    end

    // Per-master ready, hold-register capture and release.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (dp_valid_q && (dp_owner_q == 1'(i))) begin
                mx_hready_s[i] = HREADY;
            end else if (pending_s[i]) begin
                mx_hready_s[i] = 1'b0;
            end else begin
                mx_hready_s[i] = 1'b1;
            end
            release_s[i] = fwd_s && (grant_s == 1'(i)) && pending_s[i];
            capture_s[i] = mx_hready_s[i] && live_active_s[i] && !pending_s[i]
                           && !(fwd_s && (grant_s == 1'(i)));
        end
    end

    // Data-phase ownership and lock tracking advance whenever the bus is ready.
    always_comb begin
        dp_valid_d   = dp_valid_q;
        dp_owner_d   = dp_owner_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        if (HREADY) begin
            dp_valid_d = grant_active_s;
            lock_d     = src_hmastlock_s[grant_s];
            if (grant_active_s) begin
                dp_owner_d   = grant_s;
                last_grant_d = grant_s;
            end else begin
                dp_owner_d   = dp_owner_q;
                last_grant_d = last_grant_q;
            end
        end else begin
            dp_valid_d = dp_valid_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_q   <= 1'b0;
            dp_owner_q   <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_owner_q   <= dp_owner_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
        end
    end

    // Shared-bus drive and response routing, forced quiet during reset.
    always_comb begin
        HADDR     = src_haddr_s[grant_s];
        HBURST    = src_hburst_s[grant_s];
        HSIZE     = src_hsize_s[grant_s];
        HPROT     = src_hprot_s[grant_s];
        HWRITE    = src_hwrite_s[grant_s];
        HMASTLOCK = src_hmastlock_s[grant_s];
        HTRANS    = (!HRESET && grant_active_s) ? src_htrans_s[grant_s] : HTRANS_IDLE;
        HMASTER   = HRESET ? 1'b0 : grant_s;
        HWDATA    = dp_owner_q ? M1_HWDATA : M0_HWDATA;
        M0_HREADY = HRESET | mx_hready_s[0];
        M1_HREADY = HRESET | mx_hready_s[1];
        M0_HRDATA = 32'h0000_0000;
        M1_HRDATA = 32'h0000_0000;
        M0_HRESP  = HRESP_OKAY;
        M1_HRESP  = HRESP_OKAY;
        if (!HRESET && dp_valid_q) begin
            if (dp_owner_q) begin
                M1_HRDATA = HRDATA;
                M1_HRESP  = HRESP;
            end else begin
                M0_HRDATA = HRDATA;
                M0_HRESP  = HRESP;
            end
        end else begin
            M0_HRESP = HRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_lite_arbiter.sv
// Directed bench for the two-master AHB-Lite arbiter. Instance u_fix uses fixed
// priority and carries the scoreboarded scenarios; u_rr uses alternation.
module tb_mfp_ahb_lite_arbiter;

    typedef struct packed {
        logic        master;
        logic [31:0] addr;
        logic        write;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [2:0]  m0_hburst, m1_hburst, m0_hsize, m1_hsize;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite, m0_hlock, m1_hlock;
    logic [31:0] hrdata;
    logic        hready, hresp;

    logic [31:0] m0_hrdata, m1_hrdata, haddr, hwdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock, hwrite, hmaster;

    logic [31:0] r_m0_hrdata, r_m1_hrdata, r_haddr, r_hwdata;
    logic        r_m0_hready, r_m1_hready, r_m0_hresp, r_m1_hresp;
    logic [2:0]  r_hburst, r_hsize;
    logic [3:0]  r_hprot;
    logic [1:0]  r_htrans;
    logic        r_hmastlock, r_hwrite, r_hmaster;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   sb_en = 1'b1;
    bit   seen;
    exp_t sb_q[$];
    exp_t e;

    always #5 clk = ~clk;

    mfp_ahb_lite_arbiter #(.ROUND_ROBIN(0), .ADDR_WIDTH(32)) u_fix (
        .HCLK(clk), .HRESET(rst),
        .M0_HADDR(m0_haddr), .M0_HBURST(m0_hburst), .M0_HSIZE(m0_hsize), .M0_HPROT(m0_hprot),
        .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HMASTLOCK(m0_hlock), .M0_HWDATA(m0_hwdata),
        .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
        .M1_HADDR(m1_haddr), .M1_HBURST(m1_hburst), .M1_HSIZE(m1_hsize), .M1_HPROT(m1_hprot),
        .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HMASTLOCK(m1_hlock), .M1_HWDATA(m1_hwdata),
        .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
        .HADDR(haddr), .HBURST(hburst), .HMASTLOCK(hmastlock), .HPROT(hprot), .HSIZE(hsize),
        .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HMASTER(hmaster)
    );

    mfp_ahb_lite_arbiter #(.ROUND_ROBIN(1), .ADDR_WIDTH(32)) u_rr (
        .HCLK(clk), .HRESET(rst),
        .M0_HADDR(m0_haddr), .M0_HBURST(m0_hburst), .M0_HSIZE(m0_hsize), .M0_HPROT(m0_hprot),
        .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HMASTLOCK(m0_hlock), .M0_HWDATA(m0_hwdata),
        .M0_HRDATA(r_m0_hrdata), .M0_HREADY(r_m0_hready), .M0_HRESP(r_m0_hresp),
        .M1_HADDR(m1_haddr), .M1_HBURST(m1_hburst), .M1_HSIZE(m1_hsize), .M1_HPROT(m1_hprot),
        .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HMASTLOCK(m1_hlock), .M1_HWDATA(m1_hwdata),
        .M1_HRDATA(r_m1_hrdata), .M1_HREADY(r_m1_hready), .M1_HRESP(r_m1_hresp),
        .HADDR(r_haddr), .HBURST(r_hburst), .HMASTLOCK(r_hmastlock), .HPROT(r_hprot), .HSIZE(r_hsize),
        .HTRANS(r_htrans), .HWRITE(r_hwrite), .HWDATA(r_hwdata),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HMASTER(r_hmaster)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] burst, input logic lock);
        if (m == 0) begin
            m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hburst = burst; m0_hlock = lock;
        end else begin
            m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hburst = burst; m1_hlock = lock;
        end
    endtask

    task automatic push(input logic m, input logic [31:0] a, input logic w);
        exp_t x;
        x.master = m;
        x.addr   = a;
        x.write  = w;
        sb_q.push_back(x);
    endtask

    // Scoreboard: every transfer accepted on the shared bus must be the next expected one.
    always @(negedge clk) begin
        if (sb_en && !rst && htrans[1] && hready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_xfer", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_addr", 64'(haddr), 64'(e.addr));
                chk("sb_master", 64'(hmaster), 64'(e.master));
                chk("sb_write", 64'(hwrite), 64'(e.write));
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    initial begin
        rst = 1'b1; hready = 1'b1; hrdata = 32'hDEAD_BEEF; hresp = 1'b1;
        m0_hsize = 3'b010; m1_hsize = 3'b010; m0_hprot = 4'b0011; m1_hprot = 4'b0011;
        m0_hwdata = 32'h0; m1_hwdata = 32'h0;
        drv(0, 2'b10, 32'h8000_0FF0, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);

        // Reset: bus quiet, masters ready, responses zeroed even with slave driving
        next_cycle(); next_cycle(); mid();
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_m0_hready", 64'(m0_hready), 64'd1);
        chk("rst_m1_hready", 64'(m1_hready), 64'd1);
        chk("rst_hmaster", 64'(hmaster), 64'd0);
        chk("rst_m0_hrdata", 64'(m0_hrdata), 64'd0);
        chk("rst_m0_hresp", 64'(m0_hresp), 64'd0);
        chk("rst_rr_htrans", 64'(r_htrans), 64'd0);
        next_cycle();
        rst = 1'b0; hresp = 1'b0;
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);

        // Single master read, forwarded in the same cycle
        next_cycle();
        drv(0, 2'b10, 32'h8000_0010, 1'b0, 3'b000, 1'b0);
        push(1'b0, 32'h8000_0010, 1'b0);
        mid();
        chk("single_hmaster", 64'(hmaster), 64'd0);
        chk("single_htrans", 64'(htrans), 64'd2);
        chk("single_m0_hready", 64'(m0_hready), 64'd1);
        next_cycle();
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        hrdata = 32'h1234_5678;
        mid();
        chk("single_m0_hrdata", 64'(m0_hrdata), 64'h1234_5678);
        chk("single_m1_hrdata", 64'(m1_hrdata), 64'd0);
        chk("single_m0_nostall", 64'(m0_hready), 64'd1);

        // Conflict under fixed priority: M0 first, M1 parked then replayed
        next_cycle();
        drv(0, 2'b10, 32'h8000_0000, 1'b1, 3'b000, 1'b0);
        drv(1, 2'b10, 32'h8000_0004, 1'b0, 3'b000, 1'b0);
        push(1'b0, 32'h8000_0000, 1'b1);
        push(1'b1, 32'h8000_0004, 1'b0);
        mid();
        chk("conf_hmaster0", 64'(hmaster), 64'd0);
        chk("conf_m1_accept", 64'(m1_hready), 64'd1);
        next_cycle();
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        m0_hwdata = 32'hCAFE_F00D;
        mid();
        chk("conf_hmaster1", 64'(hmaster), 64'd1);
        chk("conf_haddr1", 64'(haddr), 64'h8000_0004);
        chk("conf_hwdata", 64'(hwdata), 64'hCAFE_F00D);
        chk("conf_m1_stall", 64'(m1_hready), 64'd0);
        chk("conf_m0_hready", 64'(m0_hready), 64'd1);
        next_cycle();
        hrdata = 32'hA5A5_0004;
        mid();
        chk("conf_m1_done", 64'(m1_hready), 64'd1);
        chk("conf_m1_hrdata", 64'(m1_hrdata), 64'hA5A5_0004);
        chk("conf_m0_hrdata", 64'(m0_hrdata), 64'd0);

        // Locked INCR4 from M1 holds the bus against M0
        next_cycle();
        drv(1, 2'b10, 32'h8000_0100, 1'b0, 3'b011, 1'b1);
        for (int i = 0; i < 4; i++) push(1'b1, 32'h8000_0100 + 32'(4 * i), 1'b0);
        mid();
        chk("lock_b0_hmaster", 64'(hmaster), 64'd1);
        next_cycle();
        drv(1, 2'b11, 32'h8000_0104, 1'b0, 3'b011, 1'b1);
        drv(0, 2'b10, 32'h8000_0200, 1'b0, 3'b000, 1'b0);
        push(1'b0, 32'h8000_0200, 1'b0);
        mid();
        chk("lock_b1_hmaster", 64'(hmaster), 64'd1);
        chk("lock_m0_accept", 64'(m0_hready), 64'd1);
        next_cycle();
        drv(1, 2'b11, 32'h8000_0108, 1'b0, 3'b011, 1'b1);
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        mid();
        chk("lock_b2_hmaster", 64'(hmaster), 64'd1);
        chk("lock_m0_stall", 64'(m0_hready), 64'd0);
        next_cycle();
        drv(1, 2'b11, 32'h8000_010C, 1'b0, 3'b011, 1'b1);
        mid();
        chk("lock_b3_hmaster", 64'(hmaster), 64'd1);
        next_cycle();
        drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (htrans[1] && hmaster == 1'b0) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        chk("lock_release_m0", 64'(seen), 64'd1);
        next_cycle();
        hrdata = 32'h0000_200D;
        mid();
        chk("lock_m0_hrdata", 64'(m0_hrdata), 64'h200D);
        chk("lock_m0_done", 64'(m0_hready), 64'd1);

        // Slave stall during M0 data phase while M1 requests
        next_cycle();
        drv(0, 2'b10, 32'h8000_0300, 1'b0, 3'b000, 1'b0);
        push(1'b0, 32'h8000_0300, 1'b0);
        mid();
        chk("stall_hmaster0", 64'(hmaster), 64'd0);
        next_cycle();
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b10, 32'h8000_0304, 1'b0, 3'b000, 1'b0);
        push(1'b1, 32'h8000_0304, 1'b0);
        hready = 1'b0;
        mid();
        chk("stall_c1_htrans", 64'(htrans), 64'd2);
        chk("stall_c1_hmaster", 64'(hmaster), 64'd1);
        chk("stall_c1_m0_hready", 64'(m0_hready), 64'd0);
        chk("stall_c1_m1_accept", 64'(m1_hready), 64'd1);
        for (int i = 2; i <= 3; i++) begin
            next_cycle();
            drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
            mid();
            chk("stall_htrans", 64'(htrans), 64'd2);
            chk("stall_haddr", 64'(haddr), 64'h8000_0304);
            chk("stall_m1_hready", 64'(m1_hready), 64'd0);
        end
        next_cycle();
        hready = 1'b1;
        hrdata = 32'h0000_300D;
        mid();
        chk("stall_m0_done", 64'(m0_hready), 64'd1);
        chk("stall_m0_hrdata", 64'(m0_hrdata), 64'h300D);
        chk("stall_m1_wait", 64'(m1_hready), 64'd0);

        // Two-cycle ERROR on M1's data phase
        next_cycle();
        hready = 1'b0; hresp = 1'b1;
        mid();
        chk("err1_m1_hresp", 64'(m1_hresp), 64'd1);
        chk("err1_m1_hready", 64'(m1_hready), 64'd0);
        chk("err1_m0_hresp", 64'(m0_hresp), 64'd0);
        next_cycle();
        hready = 1'b1;
        mid();
        chk("err2_m1_hready", 64'(m1_hready), 64'd1);
        chk("err2_m1_hresp", 64'(m1_hresp), 64'd1);
        chk("err2_no_dup", 64'(htrans), 64'd0);
        next_cycle();
        hresp = 1'b0;
        mid();
        chk("stall_queue_empty", 64'(sb_q.size()), 64'd0);

        // Reset while M1 is parked: the parked transfer is dropped
        next_cycle();
        drv(0, 2'b10, 32'h8000_0400, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b10, 32'h8000_0404, 1'b0, 3'b000, 1'b0);
        push(1'b0, 32'h8000_0400, 1'b0);
        mid();
        chk("rmid_hmaster", 64'(hmaster), 64'd0);
        next_cycle();
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        rst = 1'b1;
        mid();
        chk("rmid_rst_htrans", 64'(htrans), 64'd0);
        chk("rmid_rst_m1_hready", 64'(m1_hready), 64'd1);
        next_cycle();
        rst = 1'b0;
        mid();
        chk("rmid_no_replay", 64'(htrans), 64'd0);
        chk("rmid_m0_hready", 64'(m0_hready), 64'd1);
        chk("rmid_m1_hready", 64'(m1_hready), 64'd1);
        chk("rmid_queue_empty", 64'(sb_q.size()), 64'd0);

        // Alternating priority with both masters requesting continuously
        next_cycle();
        sb_en = 1'b0;
        drv(0, 2'b10, 32'h8000_0500, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b10, 32'h8000_0504, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr_hmaster", 64'(r_hmaster), 64'(i % 2));
            chk("rr_active", 64'(r_htrans[1]), 64'd1);
            next_cycle();
        end
        drv(0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_lite_arbiter.md
Name: mfp_ahb_lite_arbiter

Overview:
- Two-master AHB-Lite arbiter placed in front of the slave matrix.
- M0 is the MIPS core; M1 is a secondary master (DMA or debug loader).
- Each master sees a private AHB-Lite slave port. The block forwards one address phase per cycle to the shared bus and routes the data-phase response back to the owning master.
- A master whose address phase is accepted but cannot be forwarded is held in a one-entry pending register and stalled.

Parameters:
- ROUND_ROBIN, 0: 0 = fixed priority with M0 highest; 1 = alternating priority, where the last-granted master loses ties.
- ADDR_WIDTH, 32: width of HADDR on all ports.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  synchronous active-high reset
- M0_/M1_HADDR  in  ADDR_WIDTH  master address
- M0_/M1_HBURST, M0_/M1_HSIZE  in  3 each  master control
- M0_/M1_HPROT  in  4  master control
- M0_/M1_HTRANS  in  2  master control
- M0_/M1_HWRITE, M0_/M1_HMASTLOCK  in  1 each  master control
- M0_/M1_HWDATA  in  32  master write data
- M0_/M1_HRDATA  out  32  read data returned to the master
- M0_/M1_HREADY  out  1  per-master ready
- M0_/M1_HRESP  out  1  per-master response
- HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA  out  as master  shared bus toward the matrix
- HRDATA  in  32  from the matrix
- HREADY  in  1  from the matrix
- HRESP  in  1  from the matrix
- HMASTER  out  1  current address-phase owner

Behaviour:
- Clock and reset: single clock HCLK. HRESET is synchronous and active-high; all state resets on the HCLK edge where HRESET=1.
- Reset state: pending_0 = pending_1 = 0, dp_valid = 0, dp_owner = 0, last_grant = 1.
- Outputs while HRESET=1: HTRANS = IDLE, M0_HREADY = M1_HREADY = 1, HRESP to masters = 0, HRDATA to masters = 0, HMASTER = 0.
- Source of master x: the pending_x register if it is valid, otherwise the live inputs. Source x is active when HTRANS[1] = 1 (NONSEQ or SEQ).
- Grant (combinational):
  - Lock hold: if the last forwarded transfer came from y and had HMASTLOCK=1, or y's source is active with HTRANS = SEQ, grant y.
  - Otherwise, with one source active, grant it.
  - With both active: grant M0 if ROUND_ROBIN=0, else grant ~last_grant.
  - With none active, grant last_grant and drive HTRANS = IDLE.
- Shared bus drive: address and control come from the granted source. HMASTER = grant.
- Forwarding: a transfer is forwarded when the grant is active and HREADY=1. On the clock edge: dp_valid ← 1, dp_owner ← grant, last_grant ← grant, and the granted pending_x clears if it sourced the transfer.
- If HREADY=1 with no active grant, dp_valid ← 0.
- HWDATA = M[dp_owner]_HWDATA.
- Responses: HRDATA and HRESP go to M[dp_owner] while dp_valid; the other master gets 0/0.
- Per-master HREADY:
  - If dp_valid & dp_owner==x: Mx_HREADY = HREADY.
  - Else if pending_x: Mx_HREADY = 0.
  - Else: Mx_HREADY = 1.
- Capture rule: when Mx_HREADY=1, the live source is active, pending_x=0, and the transfer is not forwarded this cycle (grant≠x or HREADY=0), latch address/control into pending_x.
- Pending ordering: pending_x stays valid until forwarded. Mx_HREADY stays 0 until x's data phase completes, which stalls x's data phase with its HWDATA held stable.
- Error responses: a two-cycle ERROR (HRESP=1) passes through unchanged to dp_owner. A pending entry is unaffected by an error on the other master.
- Live IDLE or BUSY while not pending: never captured, never forwarded. A BUSY inside a locked burst keeps the owner.
- Simultaneous requests, both live NONSEQ: the winner is forwarded and the loser is captured in the same cycle.
- Reset mid-transfer: pending registers are dropped and dp_valid clears. The masters are reset by the same HRESET.

Decomposition:
- Package mfp_ahb_lite_pkg: HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) and HRESP OKAY/ERROR constants.
- Sub-module mfp_ahb_lite_addr_hold, instantiated twice, one per master: the pending register plus the source mux. Arbitration and response routing stay in the top module.

Test Plan:
- Single master: M0 reads 0x80000010 with M1 idle → forwarded in the same cycle, HMASTER=0, M0_HRDATA = slave data one cycle later, no stall.
- Conflict, fixed priority: both issue NONSEQ in the same cycle (M0 write 0x80000000, M1 read 0x80000004), ROUND_ROBIN=0 → M0 forwarded, M1 captured in pending_1 and stalled. Required bus order: M0 then M1; M1_HREADY returns to 1 when M1's data phase completes.
- Round-robin: ROUND_ROBIN=1, both masters continuously request → HMASTER alternates 0,1,0,1 across 4 transfers.
- Locked/burst hold: M1 issues INCR4 at 0x80000100 with HMASTLOCK=1 while M0 requests → HMASTER stays 1 for all 4 beats, then M0 is granted.
- Slave stall: matrix HREADY=0 for 3 cycles during M0's data phase while M1 is NONSEQ → M1 held in pending, HTRANS stable, no duplicate or lost transfer.
- Reset mid-transfer: HRESET asserted with pending_1 valid → next cycle HTRANS=IDLE, both Mx_HREADY=1, no replay of the dropped transfer.
